// File: rtl/wb_trace_buf.sv
// ============================================================================
// Module   : wb_trace_buf
// Purpose  : Writeback commit trace buffer. It captures {seq, rd, data} for
//            every commit into a FWFT FIFO, and counts drops on overflow.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_trace_buf #(
  parameter int DEPTH   = 8,
  parameter int DATA_WD = 32,
  parameter int REG_AW  = 5,
  parameter int SEQ_WD  = 16,
  parameter int DROP_WD = 8
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       wb_valid,
  input  logic [REG_AW-1:0]          wb_rd,
  input  logic [DATA_WD-1:0]         wb_data,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [SEQ_WD-1:0]          out_seq,
  output logic [REG_AW-1:0]          out_rd,
  output logic [DATA_WD-1:0]         out_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty,
  output logic                       overflow,
  output logic [DROP_WD-1:0]         drop_cnt
);

  localparam int PW   = $clog2(DEPTH);
  localparam int CW   = PW + 1;
  localparam int RECW = SEQ_WD + REG_AW + DATA_WD;

  logic [RECW-1:0]    mem_q [DEPTH];
  logic [PW-1:0]      wptr_q, wptr_d;
  logic [PW-1:0]      rptr_q, rptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic [SEQ_WD-1:0]  seq_q, seq_d;
  logic               overflow_q, overflow_d;
  logic [DROP_WD-1:0] drop_cnt_q, drop_cnt_d;

  logic pop;
  logic push_req;
  logic push;
  logic drop;

  assign empty     = (count_q == '0);
  assign full      = (count_q == CW'(DEPTH));
  assign out_valid = ~empty;
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign drop_cnt  = drop_cnt_q;

  // Head record is read straight from storage, so out_* depend only on state.
  assign {out_seq, out_rd, out_data} = mem_q[rptr_q];

  always_comb begin
    pop      = out_valid & out_ready & ~flush;
    push_req = wb_valid & ~flush;
    // A pop in the same cycle frees the slot, so a full buffer still accepts.
    push     = push_req & (~full | pop);
    drop     = push_req & full & ~pop;

    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    seq_d      = wb_valid ? seq_q + SEQ_WD'(1) : seq_q;

    if (flush) begin
      wptr_d     = '0;
      rptr_d     = '0;
      count_d    = '0;
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end else begin
      if (push) wptr_d = wptr_q + PW'(1);
      if (pop)  rptr_d = rptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      if (drop) begin
        overflow_d = 1'b1;
        if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + DROP_WD'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      seq_q      <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      if (push) mem_q[wptr_q] <= {seq_q, wb_rd, wb_data};
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      seq_q      <= seq_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_wb_trace_buf.sv
// ============================================================================
// Module   : tb_wb_trace_buf
// Purpose  : Self-checking bench for wb_trace_buf (vector table, directed
//            corner sequences, randomized traffic against a queue model).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_trace_buf;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        wb_valid = 1'b0;
  logic [4:0]  wb_rd = '0;
  logic [31:0] wb_data = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_seq;
  logic [4:0]  out_rd;
  logic [31:0] out_data;
  logic [3:0]  count;
  logic        full;
  logic        empty;
  logic        overflow;
  logic [7:0]  drop_cnt;

  wb_trace_buf #(.DEPTH(DEPTH), .DATA_WD(32), .REG_AW(5), .SEQ_WD(16), .DROP_WD(8)) dut (
    .clk(clk), .resetn(resetn), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_seq(out_seq),
    .out_rd(out_rd), .out_data(out_data), .count(count), .full(full), .empty(empty),
    .overflow(overflow), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] seq;
    logic [4:0]  rd;
    logic [31:0] data;
  } rec_t;

  rec_t        mq[$];
  int unsigned m_seq;
  logic        m_ovf;
  int unsigned m_drop;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_seq  = 0;
    m_ovf  = 1'b0;
    m_drop = 0;
  endtask

  task automatic check_model();
    chk("count", 64'(count), 64'(mq.size()));
    chk("empty", 64'(empty), 64'(mq.size() == 0));
    chk("full", 64'(full), 64'(mq.size() == DEPTH));
    chk("out_valid", 64'(out_valid), 64'(mq.size() != 0));
    chk("overflow", 64'(overflow), 64'(m_ovf));
    chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
    if (mq.size() != 0) begin
      chk("out_seq", 64'(out_seq), 64'(mq[0].seq));
      chk("out_rd", 64'(out_rd), 64'(mq[0].rd));
      chk("out_data", 64'(out_data), 64'(mq[0].data));
    end
  endtask

  // One clock: drive inputs, predict, clock, compare.
  task automatic step(input logic wv, input logic [4:0] rd, input logic [31:0] d,
                      input logic fl, input logic rdy);
    bit pop_m, was_full;
    rec_t r;
    wb_valid = wv; wb_rd = rd; wb_data = d; flush = fl; out_ready = rdy;
    was_full = (mq.size() == DEPTH);
    pop_m    = (mq.size() != 0) && rdy && !fl;
    if (fl) begin
      mq.delete(); m_ovf = 1'b0; m_drop = 0;
    end else begin
      if (pop_m) void'(mq.pop_front());
      if (wv) begin
        if (!was_full || pop_m) begin
          r.seq = 16'(m_seq); r.rd = rd; r.data = d;
          mq.push_back(r);
        end else begin
          m_ovf = 1'b1;
          if (m_drop < 255) m_drop++;
        end
      end
    end
    if (wv) m_seq = (m_seq + 1) % 65536;
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic do_reset();
    wb_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    #2 resetn = 1'b0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #3 resetn = 1'b1;
  endtask

  typedef struct {
    logic        wv;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        rdy;
    logic [3:0]  e_cnt;
    logic        e_vld;
    logic [15:0] e_seq;
    logic [4:0]  e_rd;
    logic [31:0] e_data;
  } vec_t;

  vec_t tbl[6];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{1'b1, 5'd1, 32'h11, 1'b0, 4'd1, 1'b1, 16'd0, 5'd1, 32'h11};
    tbl[1] = '{1'b1, 5'd2, 32'h22, 1'b0, 4'd2, 1'b1, 16'd0, 5'd1, 32'h11};
    tbl[2] = '{1'b1, 5'd3, 32'h33, 1'b0, 4'd3, 1'b1, 16'd0, 5'd1, 32'h11};
    tbl[3] = '{1'b0, 5'd0, 32'h0,  1'b1, 4'd2, 1'b1, 16'd1, 5'd2, 32'h22};
    tbl[4] = '{1'b0, 5'd0, 32'h0,  1'b1, 4'd1, 1'b1, 16'd2, 5'd3, 32'h33};
    tbl[5] = '{1'b0, 5'd0, 32'h0,  1'b1, 4'd0, 1'b0, 16'd0, 5'd0, 32'h0};

    // Reset state
    do_reset();
    #1;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    chk("rst_drop", 64'(drop_cnt), 64'd0);
    chk("rst_out", 64'({out_seq, out_rd, out_data}), 64'd0);

    // Basic capture and drain, against fixed vectors
    for (int i = 0; i < 6; i++) begin
      step(tbl[i].wv, tbl[i].rd, tbl[i].data, 1'b0, tbl[i].rdy);
      chk("tbl_count", 64'(count), 64'(tbl[i].e_cnt));
      chk("tbl_valid", 64'(out_valid), 64'(tbl[i].e_vld));
      if (tbl[i].e_vld) begin
        chk("tbl_seq", 64'(out_seq), 64'(tbl[i].e_seq));
        chk("tbl_rd", 64'(out_rd), 64'(tbl[i].e_rd));
        chk("tbl_data", 64'(out_data), 64'(tbl[i].e_data));
      end
    end

    // Overflow by two, drain, next commit shows the gap
    do_reset();
    for (int i = 0; i < 10; i++) step(1'b1, 5'(i), 32'(i * 3), 1'b0, 1'b0);
    chk("ovf_full", 64'(full), 64'd1);
    chk("ovf_flag", 64'(overflow), 64'd1);
    chk("ovf_drop", 64'(drop_cnt), 64'd2);
    for (int i = 0; i < 8; i++) begin
      chk("ovf_drain_seq", 64'(out_seq), 64'(i));
      step(1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
    end
    chk("ovf_drained", 64'(empty), 64'd1);
    step(1'b1, 5'd9, 32'hdead, 1'b0, 1'b0);
    chk("ovf_next_seq", 64'(out_seq), 64'd10);

    // Full plus simultaneous push and pop
    do_reset();
    for (int i = 0; i < 8; i++) step(1'b1, 5'(i), 32'(i), 1'b0, 1'b0);
    step(1'b1, 5'd7, 32'habc, 1'b0, 1'b1);
    chk("fpp_count", 64'(count), 64'd8);
    chk("fpp_drop", 64'(drop_cnt), 64'd0);
    chk("fpp_ovf", 64'(overflow), 64'd0);
    for (int i = 0; i < 7; i++) step(1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
    chk("fpp_tail_data", 64'(out_data), 64'habc);
    chk("fpp_tail_seq", 64'(out_seq), 64'd8);
    step(1'b0, 5'd0, 32'd0, 1'b0, 1'b1);

    // Streaming at one record per cycle, pointers wrap twice
    do_reset();
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 5'(i), 32'(i + 100), 1'b0, 1'b1);
      chk("stream_seq", 64'(out_seq), 64'(i));
      chk("stream_count", 64'(count), 64'd1);
    end
    step(1'b0, 5'd0, 32'd0, 1'b0, 1'b1);

    // Drop-counter saturation, then flush
    do_reset();
    for (int i = 0; i < 8; i++) step(1'b1, 5'd1, 32'(i), 1'b0, 1'b0);
    for (int i = 0; i < 260; i++) step(1'b1, 5'd2, 32'(i), 1'b0, 1'b0);
    chk("sat_drop", 64'(drop_cnt), 64'd255);
    step(1'b1, 5'd3, 32'h5, 1'b1, 1'b1);
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_ovf", 64'(overflow), 64'd0);
    chk("flush_drop", 64'(drop_cnt), 64'd0);
    step(1'b1, 5'd4, 32'h6, 1'b0, 1'b0);
    chk("flush_seq_cont", 64'(out_seq), 64'd269);

    // Randomized traffic
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      logic wv, rdy, fl;
      wv  = ($urandom % 4) != 0;
      rdy = (i < 750) ? (($urandom % 4) == 0) : (($urandom % 3) != 0);
      fl  = ($urandom % 64) == 0;
      step(wv, 5'($urandom), 32'($urandom), fl, rdy);
    end

    // Asynchronous reset in the middle of a drain
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 5'(i), 32'(i), 1'b0, 1'b0);
    step(1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
    #2 resetn = 1'b0;
    #1;
    chk("arst_valid", 64'(out_valid), 64'd0);
    chk("arst_count", 64'(count), 64'd0);
    chk("arst_empty", 64'(empty), 64'd1);
    model_reset();
    wb_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk);
    #3 resetn = 1'b1;
    step(1'b1, 5'd17, 32'h77, 1'b0, 1'b0);
    chk("arst_first_seq", 64'(out_seq), 64'd0);
    chk("arst_first_data", 64'(out_data), 64'h77);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
